// File: rtl/conv_wb_frontend.sv
// conv_wb_frontend: Wishbone-classic slave front-end (register file, RAM steering, run tracking) for the convolution engine
module conv_wb_frontend #(
  parameter int ADDR_HI = 31,
  parameter int ADDR_LO = 24,
  parameter logic [ADDR_HI-ADDR_LO:0] BASE_ADDR = 8'h30,
  parameter int SEL_LSB = 10,
  parameter int IMG_AW = 8,
  parameter int KERN_AW = 6,
  parameter int RES_AW = 6,
  parameter int DWIDTH = 24,
  parameter int RES_W = 20,
  parameter int RD_LAT = 1
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic               img_we,
  output logic               kern_we,
  output logic [IMG_AW-1:0]  img_wadr,
  output logic [KERN_AW-1:0] kern_wadr,
  output logic [DWIDTH-1:0]  ram_wdat,
  output logic [RES_AW-1:0]  res_radr,
  input  logic [RES_W-1:0]   res_rdat,
  output logic               eng_start,
  output logic               eng_soft_rst,
  input  logic               eng_done,
  output logic [31:0]        cfg0,
  output logic [31:0]        cfg1,
  output logic               irq
);
  localparam int IW = SEL_LSB - 2;
  localparam logic [31:0] ID = {8'hC2, 8'(RES_W), 8'(DWIDTH), 8'h01};
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t state;
  logic cnt, rd_res, irq_en, busy, done, err, done_q;
  logic [31:0] rd_reg, reg_rdata, cycles;
  logic [1:0] region;
  logic [IW-1:0] idx;
  logic valid, wr, reg_wr, start_req, start_ok, start_bad, ram_wr, ram_ok, rise, w1c_done, w1c_err;
  logic unused_adr;
  assign unused_adr = ^{wbs_adr_i[1:0], wbs_adr_i[ADDR_LO-1:SEL_LSB+2]};
  assign valid = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[ADDR_HI:ADDR_LO] == BASE_ADDR);
  assign region = wbs_adr_i[SEL_LSB+1:SEL_LSB];
  assign idx = wbs_adr_i[SEL_LSB-1:2];
  assign wr = (state == IDLE) & valid & wbs_we_i;
  assign reg_wr = wr & (region == 2'd0);
  assign start_req = reg_wr & (idx == IW'(0)) & wbs_dat_i[0];
  assign start_ok = start_req & ~busy & ~eng_soft_rst;
  assign start_bad = start_req & ~start_ok;
  assign ram_wr = wr & ((region == 2'd1) | (region == 2'd2));
  assign ram_ok = ~busy & (wbs_sel_i == 4'hF);
  assign rise = eng_done & ~done_q;
  assign w1c_done = reg_wr & (idx == IW'(1)) & wbs_dat_i[1];
  assign w1c_err = reg_wr & (idx == IW'(1)) & wbs_dat_i[2];
  assign irq = done & irq_en;
  assign wbs_dat_o = wbs_ack_o ? (rd_res ? 32'($signed(res_rdat)) : rd_reg) : 32'h0;
  // register read mux, snapshotted when a read is accepted
  always_comb begin
    reg_rdata = idx == IW'(0) ? {29'h0, irq_en, eng_soft_rst, 1'b0} :
                idx == IW'(1) ? {29'h0, err, done, busy} :
                idx == IW'(2) ? cfg0 :
                idx == IW'(3) ? cfg1 :
                idx == IW'(4) ? cycles :
                idx == IW'(5) ? ID : 32'h0;
  end
  // bus handshake: writes ack next cycle, reads wait RD_LAT cycles for the result RAM
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wbs_ack_o <= 1'b0;
      cnt <= 1'b0;
      rd_res <= 1'b0;
      rd_reg <= 32'h0;
      res_radr <= '0;
    end else begin
      case (state)
        IDLE: if (valid) begin
          state <= wbs_we_i ? ACK : WAIT;
          wbs_ack_o <= wbs_we_i;
          cnt <= 1'(RD_LAT - 1);
          rd_res <= ~wbs_we_i & (region == 2'd3);
          rd_reg <= (~wbs_we_i & (region == 2'd0)) ? reg_rdata : 32'h0;
          if (!wbs_we_i) res_radr <= idx[RES_AW-1:0];
        end
        WAIT: if (cnt == 1'b0) begin
          state <= ACK;
          wbs_ack_o <= 1'b1;
        end else cnt <= cnt - 1'b1;
        ACK: begin
          state <= IDLE;
          wbs_ack_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // control, status, config and run-cycle registers
  always_ff @(posedge clk) begin
    if (reset) begin
      eng_soft_rst <= 1'b0;
      irq_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      done_q <= 1'b0;
      eng_start <= 1'b0;
      cfg0 <= 32'h0;
      cfg1 <= 32'h0;
      cycles <= 32'h0;
    end else begin
      eng_start <= start_ok;
      done_q <= eng_done;
      if (reg_wr && idx == IW'(0)) begin
        eng_soft_rst <= wbs_dat_i[1];
        irq_en <= wbs_dat_i[2];
      end
      for (int b = 0; b < 4; b++) begin
        if (reg_wr && idx == IW'(2) && wbs_sel_i[b]) cfg0[8*b +: 8] <= wbs_dat_i[8*b +: 8];
        if (reg_wr && idx == IW'(3) && wbs_sel_i[b]) cfg1[8*b +: 8] <= wbs_dat_i[8*b +: 8];
      end
      busy <= eng_soft_rst ? 1'b0 : start_ok ? 1'b1 : rise ? 1'b0 : busy;
      done <= (rise & busy) | (done & ~w1c_done & ~start_ok);
      err <= start_bad | (ram_wr & ~ram_ok) | (err & ~w1c_err);
      cycles <= start_ok ? 32'h0 : (busy & ~eng_soft_rst & ~&cycles) ? cycles + 32'h1 : cycles;
    end
  end
  // image/kernel RAM write strobes, suppressed while busy or on partial-word writes
  always_ff @(posedge clk) begin
    if (reset) begin
      img_we <= 1'b0;
      kern_we <= 1'b0;
      img_wadr <= '0;
      kern_wadr <= '0;
      ram_wdat <= '0;
    end else begin
      img_we <= ram_wr & ram_ok & (region == 2'd1);
      kern_we <= ram_wr & ram_ok & (region == 2'd2);
      if (wr) begin
        img_wadr <= idx[IMG_AW-1:0];
        kern_wadr <= idx[KERN_AW-1:0];
        ram_wdat <= wbs_dat_i[DWIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_conv_wb_frontend.sv
// tb_conv_wb_frontend: directed checks of the convolution engine bus front-end
module tb_conv_wb_frontend;
  logic clk = 1'b0, reset = 1'b1;
  logic cyc = 1'b0, stb = 1'b0, cyc2 = 1'b0, stb2 = 1'b0, wb_we = 1'b0;
  logic [3:0] sel = 4'h0;
  logic [31:0] adr = 32'h0, wdat = 32'h0;
  logic ack, ack2, img_we, kern_we, img_we2, kern_we2, eng_start, eng_start2;
  logic eng_soft_rst, eng_soft_rst2, irq, irq2, eng_done = 1'b0;
  logic [31:0] dato, dato2, cfg0, cfg1, cfg0_2, cfg1_2;
  logic [7:0] img_wadr, img_wadr2;
  logic [5:0] kern_wadr, kern_wadr2, radr, radr2;
  logic [23:0] ram_wdat, ram_wdat2;
  logic [19:0] rdat = 20'h0, rdat2 = 20'h0, rdat2_p = 20'h0;
  int errors = 0, checks = 0;
  int start_cnt = 0, img_cnt = 0, kern_cnt = 0, ack_cnt = 0;
  logic [7:0] img_last = 8'h0;
  logic [5:0] kern_last = 6'h0;
  logic [23:0] img_dat_last = 24'h0;
  int lat;
  logic [31:0] rd;

  always #5 clk = ~clk;

  conv_wb_frontend dut (
    .clk(clk), .reset(reset), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(wb_we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(dato),
    .img_we(img_we), .kern_we(kern_we), .img_wadr(img_wadr), .kern_wadr(kern_wadr),
    .ram_wdat(ram_wdat), .res_radr(radr), .res_rdat(rdat), .eng_start(eng_start),
    .eng_soft_rst(eng_soft_rst), .eng_done(eng_done), .cfg0(cfg0), .cfg1(cfg1), .irq(irq)
  );

  conv_wb_frontend #(.RD_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .wbs_cyc_i(cyc2), .wbs_stb_i(stb2), .wbs_we_i(wb_we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack2), .wbs_dat_o(dato2),
    .img_we(img_we2), .kern_we(kern_we2), .img_wadr(img_wadr2), .kern_wadr(kern_wadr2),
    .ram_wdat(ram_wdat2), .res_radr(radr2), .res_rdat(rdat2), .eng_start(eng_start2),
    .eng_soft_rst(eng_soft_rst2), .eng_done(1'b0), .cfg0(cfg0_2), .cfg1(cfg1_2), .irq(irq2)
  );

  function automatic logic [19:0] res_val(input logic [5:0] a);
    return (a == 6'd3) ? 20'hFFFFE : {14'h0, a};
  endfunction

  function automatic logic [31:0] wa(input logic [1:0] r, input logic [7:0] i);
    return {8'h30, 12'h0, r, i, 2'b00};
  endfunction

  // result RAM models (latency 1 and 2) and pulse monitors
  always @(posedge clk) begin
    rdat <= res_val(radr);
    rdat2_p <= res_val(radr2);
    rdat2 <= rdat2_p;
    if (eng_start) start_cnt <= start_cnt + 1;
    if (ack) ack_cnt <= ack_cnt + 1;
    if (img_we) begin img_cnt <= img_cnt + 1; img_last <= img_wadr; img_dat_last <= ram_wdat; end
    if (kern_we) begin kern_cnt <= kern_cnt + 1; kern_last <= kern_wadr; end
  end

  task automatic bus_op(input bit two, input bit we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int l, output logic [31:0] r);
    @(posedge clk); #1;
    adr = a; wb_we = we; wdat = d; sel = s;
    if (two) begin cyc2 = 1'b1; stb2 = 1'b1; end else begin cyc = 1'b1; stb = 1'b1; end
    l = -1; r = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (two ? ack2 : ack) begin l = i; r = two ? dato2 : dato; break; end
    end
    cyc = 1'b0; stb = 1'b0; cyc2 = 1'b0; stb2 = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({ack, ack2, img_we, kern_we, eng_start, eng_soft_rst, irq} !== 7'h0) begin errors++; $display("FAIL reset_ctl got %b exp 0", {ack, ack2, img_we, kern_we, eng_start, eng_soft_rst, irq}); end
    checks++; if (dato !== 32'h0) begin errors++; $display("FAIL reset_dat got %h exp 0", dato); end
    checks++; if ({cfg0, cfg1} !== 64'h0) begin errors++; $display("FAIL reset_cfg got %h exp 0", {cfg0, cfg1}); end
    reset = 1'b0;
  endtask

  task automatic test_cfg;
    bus_op(0, 1, wa(0, 2), 32'h1234_5678, 4'h3, lat, rd);
    checks++; if (lat !== 1) begin errors++; $display("FAIL cfg_wr_lat got %0d exp 1", lat); end
    checks++; if (cfg0 !== 32'h0000_5678) begin errors++; $display("FAIL cfg0_port got %h exp 00005678", cfg0); end
    bus_op(0, 0, wa(0, 2), 32'h0, 4'hF, lat, rd);
    checks++; if (lat !== 2) begin errors++; $display("FAIL cfg_rd_lat got %0d exp 2", lat); end
    checks++; if (rd !== 32'h0000_5678) begin errors++; $display("FAIL cfg0_rd got %h exp 00005678", rd); end
    bus_op(0, 1, wa(0, 3), 32'hDEAD_BEEF, 4'hC, lat, rd);
    checks++; if (cfg1 !== 32'hDEAD_0000) begin errors++; $display("FAIL cfg1_port got %h exp dead0000", cfg1); end
  endtask

  task automatic test_image;
    int c0;
    c0 = img_cnt;
    bus_op(0, 1, wa(1, 5), 32'h00AB_CDEF, 4'hF, lat, rd);
    @(posedge clk); #1;
    checks++; if (img_cnt !== c0 + 1) begin errors++; $display("FAIL img_we_cnt got %0d exp %0d", img_cnt, c0 + 1); end
    checks++; if (img_last !== 8'd5) begin errors++; $display("FAIL img_wadr got %0d exp 5", img_last); end
    checks++; if (img_dat_last !== 24'hABCDEF) begin errors++; $display("FAIL ram_wdat got %h exp abcdef", img_dat_last); end
    bus_op(0, 0, wa(1, 5), 32'h0, 4'hF, lat, rd);
    checks++; if (rd !== 32'h0 || lat !== 2) begin errors++; $display("FAIL img_rd got %h lat %0d exp 0 lat 2", rd, lat); end
    bus_op(0, 1, 32'h3100_0414, 32'h0011_2233, 4'hF, lat, rd);
    checks++; if (lat !== -1) begin errors++; $display("FAIL bad_base_ack got lat %0d exp no ack", lat); end
    checks++; if (img_cnt !== c0 + 1) begin errors++; $display("FAIL bad_base_we got %0d exp %0d", img_cnt, c0 + 1); end
  endtask

  task automatic test_start;
    int s0;
    s0 = start_cnt;
    bus_op(0, 1, wa(0, 0), 32'h4, 4'hF, lat, rd);
    bus_op(0, 1, wa(0, 0), 32'h5, 4'hF, lat, rd);
    checks++; if (eng_start !== 1'b1) begin errors++; $display("FAIL start_pulse got %b exp 1", eng_start); end
    bus_op(0, 0, wa(0, 1), 32'h0, 4'hF, lat, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL status_busy got %h exp 1", rd); end
    repeat (6) @(posedge clk);
    #1 eng_done = 1'b1;
    repeat (2) @(posedge clk);
    bus_op(0, 0, wa(0, 4), 32'h0, 4'hF, lat, rd);
    checks++; if (rd !== 32'd10) begin errors++; $display("FAIL cycles got %0d exp 10", rd); end
    bus_op(0, 0, wa(0, 1), 32'h0, 4'hF, lat, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL status_done got %h exp 2", rd); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq got %b exp 1", irq); end
    checks++; if (start_cnt !== s0 + 1) begin errors++; $display("FAIL start_cnt got %0d exp %0d", start_cnt, s0 + 1); end
  endtask

  task automatic test_busy_errors;
    int s0, k0;
    eng_done = 1'b0;
    @(posedge clk);
    s0 = start_cnt; k0 = kern_cnt;
    bus_op(0, 1, wa(0, 0), 32'h5, 4'hF, lat, rd);
    bus_op(0, 1, wa(2, 2), 32'h0000_0077, 4'hF, lat, rd);
    checks++; if (lat !== 1) begin errors++; $display("FAIL busy_kern_ack got %0d exp 1", lat); end
    bus_op(0, 1, wa(0, 0), 32'h5, 4'hF, lat, rd);
    bus_op(0, 0, wa(0, 1), 32'h0, 4'hF, lat, rd);
    checks++; if (rd !== 32'h5) begin errors++; $display("FAIL status_busy_err got %h exp 5", rd); end
    checks++; if (start_cnt !== s0 + 1 || kern_cnt !== k0) begin errors++; $display("FAIL busy_suppress got start %0d kern %0d exp %0d %0d", start_cnt, kern_cnt, s0 + 1, k0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_busy got %b exp 0", irq); end
    eng_done = 1'b1;
    repeat (2) @(posedge clk);
    #1 eng_done = 1'b0;
    bus_op(0, 1, wa(0, 1), 32'h4, 4'hF, lat, rd);
    bus_op(0, 0, wa(0, 1), 32'h0, 4'hF, lat, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL err_w1c got %h exp 2", rd); end
    bus_op(0, 1, wa(0, 1), 32'h2, 4'hF, lat, rd);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL done_w1c_irq got %b exp 0", irq); end
    bus_op(0, 1, wa(2, 9), 32'h0000_0099, 4'hF, lat, rd);
    @(posedge clk); #1;
    checks++; if (kern_cnt !== k0 + 1 || kern_last !== 6'd9) begin errors++; $display("FAIL kern_wr got cnt %0d adr %0d exp %0d 9", kern_cnt, kern_last, k0 + 1); end
    bus_op(0, 1, wa(2, 4), 32'h0000_0044, 4'h7, lat, rd);
    bus_op(0, 0, wa(0, 1), 32'h0, 4'hF, lat, rd);
    checks++; if (rd !== 32'h4 || kern_cnt !== k0 + 1) begin errors++; $display("FAIL kern_partial got status %h cnt %0d exp 4 %0d", rd, kern_cnt, k0 + 1); end
    bus_op(0, 1, wa(0, 1), 32'h4, 4'hF, lat, rd);
  endtask

  task automatic test_soft_rst;
    int s0;
    s0 = start_cnt;
    bus_op(0, 1, wa(0, 0), 32'h2, 4'hF, lat, rd);
    checks++; if (eng_soft_rst !== 1'b1) begin errors++; $display("FAIL soft_rst got %b exp 1", eng_soft_rst); end
    bus_op(0, 1, wa(0, 0), 32'h3, 4'hF, lat, rd);
    bus_op(0, 0, wa(0, 1), 32'h0, 4'hF, lat, rd);
    checks++; if (rd !== 32'h4 || start_cnt !== s0) begin errors++; $display("FAIL soft_start got status %h starts %0d exp 4 %0d", rd, start_cnt, s0); end
    bus_op(0, 1, wa(0, 0), 32'h0, 4'hF, lat, rd);
    bus_op(0, 1, wa(0, 1), 32'h4, 4'hF, lat, rd);
    checks++; if (eng_soft_rst !== 1'b0) begin errors++; $display("FAIL soft_clr got %b exp 0", eng_soft_rst); end
  endtask

  task automatic test_result;
    bus_op(0, 0, wa(3, 3), 32'h0, 4'hF, lat, rd);
    checks++; if (rd !== 32'hFFFF_FFFE || lat !== 2) begin errors++; $display("FAIL res_neg got %h lat %0d exp fffffffe lat 2", rd, lat); end
    bus_op(0, 0, wa(3, 7), 32'h0, 4'hF, lat, rd);
    checks++; if (rd !== 32'h7) begin errors++; $display("FAIL res_pos got %h exp 7", rd); end
    bus_op(1, 0, wa(3, 3), 32'h0, 4'hF, lat, rd);
    checks++; if (rd !== 32'hFFFF_FFFE || lat !== 3) begin errors++; $display("FAIL res_lat2 got %h lat %0d exp fffffffe lat 3", rd, lat); end
    bus_op(1, 0, wa(3, 9), 32'h0, 4'hF, lat, rd);
    checks++; if (rd !== 32'h9) begin errors++; $display("FAIL res_lat2_b got %h exp 9", rd); end
    bus_op(0, 0, wa(0, 5), 32'h0, 4'hF, lat, rd);
    checks++; if (rd !== 32'hC214_1801) begin errors++; $display("FAIL id got %h exp c2141801", rd); end
  endtask

  task automatic test_reset_mid;
    int a0;
    @(posedge clk); #1;
    adr = wa(3, 7); wb_we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    a0 = ack_cnt;
    checks++; if (radr !== 6'd7) begin errors++; $display("FAIL mid_radr got %0d exp 7", radr); end
    reset = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    checks++; if ({ack, img_we, kern_we, eng_start, irq} !== 5'h0 || dato !== 32'h0 || radr !== 6'd0 || cfg1 !== 32'h0) begin errors++; $display("FAIL mid_reset_out got ack %b dat %h radr %0d cfg1 %h exp 0", ack, dato, radr, cfg1); end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ack_cnt !== a0) begin errors++; $display("FAIL mid_no_ack got %0d exp %0d", ack_cnt, a0); end
    bus_op(0, 0, wa(3, 7), 32'h0, 4'hF, lat, rd);
    checks++; if (rd !== 32'h7 || lat !== 2) begin errors++; $display("FAIL post_reset_rd got %h lat %0d exp 7 lat 2", rd, lat); end
  endtask

  initial begin
    test_reset();
    test_cfg();
    test_image();
    test_start();
    test_busy_errors();
    test_soft_rst();
    test_result();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
